riscv_irq_ctrl_vec: RTL and testbench

//  Parametrised successor to the core's fixed 16-line interrupt controller.
//  - Supports NUM_IRQ lines, each configurable as level- or rising-edge-triggered.
//  - Latches edge requests, arbitrates with fixed priority and raises a same-cycle trap request.
//  - Tracks the in-service line until mret and then pulses its return/ack line.
//  - Sits between SoC peripherals and the core's trap/CSR logic.
//

---
 rtl/riscv_irq_ctrl_vec.sv | 116 +++++++++++
 tb/tb_riscv_irq_ctrl_vec.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_irq_ctrl_vec.sv
// Vectored interrupt controller: level/edge request capture, fixed-priority arbitration,
// single in-service tracking until mret with a one-hot return acknowledge.
module riscv_irq_ctrl_vec #(
    parameter int unsigned          NUM_IRQ    = 16,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = '0,
    parameter logic [31:0]          CAUSE_BASE = 32'h8000_0010,
    localparam int unsigned         ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               exception_i,
    input  logic               global_en_i,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic [NUM_IRQ-1:0] mie_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic [NUM_IRQ-1:0] irq_ret_o,
    output logic               busy_o
);

    typedef enum logic {
        IDLE,
        SERVICE
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_IRQ-1:0] req_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;

    logic [NUM_IRQ-1:0] eff_pend;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] take_clr;
    logic [ID_W-1:0]    winner;
    logic               take;

    // Edge lines use the latched bit, level lines are passed straight through.
    assign eff_pend = (pend_q & EDGE_MASK) | (irq_req_i & ~EDGE_MASK);
    assign cand     = eff_pend & mie_i;
    assign edge_set = irq_req_i & ~req_q & EDGE_MASK;

    // NOTE: every variable in an always_comb gets a default before any branch, so no latch is inferred.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        take      = 1'b0;
        irq_o     = 1'b0;
        busy_o    = 1'b0;
        irq_id_o  = '0;
        irq_ret_o = '0;

        unique case (state_q)
            IDLE: begin
                take     = global_en_i & ~exception_i & (|cand);
                irq_o    = take;
                irq_id_o = winner;
                if (take) begin
                    state_d = SERVICE;
                    id_d    = winner;
                end
            end
            SERVICE: begin
                busy_o   = 1'b1;
                irq_id_o = id_q;
                if (mret_i) begin
                    irq_ret_o = NUM_IRQ'(1) << id_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs must go quiet the instant reset asserts, not at the next edge.
        if (!rst_i) begin
            take      = 1'b0;
            irq_o     = 1'b0;
            busy_o    = 1'b0;
            irq_id_o  = '0;
            irq_ret_o = '0;
        end
    end

    assign irq_cause_o = CAUSE_BASE + 32'(irq_id_o);

    // A fresh edge on the same cycle as the take wins over the clear.
    assign take_clr = take ? (NUM_IRQ'(1) << winner) : '0;
    assign pend_d   = ((pend_q & ~take_clr) | edge_set) & EDGE_MASK;

    // NOTE: sequential state is updated with non-blocking assignments only, so all flops sample together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            req_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            req_q   <= irq_req_i;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_riscv_irq_ctrl_vec.sv
// Directed bench for riscv_irq_ctrl_vec: a 16-line instance with line 0 edge-triggered,
// plus a small instance whose cause base sits next to the 32-bit wrap point.
module tb_riscv_irq_ctrl_vec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc;
    logic        gen;
    logic [15:0] req;
    logic [15:0] mie;
    logic        mret;
    logic        irq;
    logic [31:0] cause;
    logic [3:0]  id;
    logic [15:0] ret;
    logic        busy;

    logic        gen_b;
    logic [3:0]  req_b;
    logic        irq_b;
    logic [31:0] cause_b;
    logic [1:0]  id_b;
    logic [3:0]  ret_b;
    logic        busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_irq_ctrl_vec #(
        .NUM_IRQ    (16),
        .EDGE_MASK  (16'h0001),
        .CAUSE_BASE (32'h8000_0010)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .exception_i (exc),
        .global_en_i (gen),
        .irq_req_i   (req),
        .mie_i       (mie),
        .mret_i      (mret),
        .irq_o       (irq),
        .irq_cause_o (cause),
        .irq_id_o    (id),
        .irq_ret_o   (ret),
        .busy_o      (busy)
    );

    riscv_irq_ctrl_vec #(
        .NUM_IRQ    (4),
        .EDGE_MASK  (4'h0),
        .CAUSE_BASE (32'hFFFF_FFFE)
    ) dut_wrap (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .exception_i (1'b0),
        .global_en_i (gen_b),
        .irq_req_i   (req_b),
        .mie_i       (4'hF),
        .mret_i      (1'b0),
        .irq_o       (irq_b),
        .irq_cause_o (cause_b),
        .irq_id_o    (id_b),
        .irq_ret_o   (ret_b),
        .busy_o      (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        exc   = 1'b0;
        gen   = 1'b1;
        req   = 16'h0024;
        mie   = 16'hFFFF;
        mret  = 1'b0;
        gen_b = 1'b0;
        req_b = 4'h0;
        #2;
        check("rst_irq_forced", 32'(irq), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_id", 32'(id), 32'h0);
        check("rst_cause", cause, 32'h8000_0010);
        check("rst_ret", 32'(ret), 32'h0);
        req = 16'h0000;
        repeat (2) tick();
        rst_n = 1'b1;

        // 1: level requests on lines 2 and 5, line 2 wins in the same cycle
        tick();
        #1;
        check("t1_idle_irq", 32'(irq), 32'h0);
        req = 16'h0024;
        #1;
        check("t1_irq", 32'(irq), 32'h1);
        check("t1_id", 32'(id), 32'd2);
        check("t1_cause", cause, 32'h8000_0012);
        check("t1_busy_pre", 32'(busy), 32'h0);

        // wrap instance: cause is a modulo-2^32 add
        gen_b = 1'b1;
        req_b = 4'b1000;
        #1;
        check("wrap_id3", 32'(id_b), 32'd3);
        check("wrap_cause3", cause_b, 32'h0000_0001);
        req_b = 4'b1100;
        #1;
        check("wrap_cause2", cause_b, 32'h0000_0000);
        gen_b = 1'b0;
        req_b = 4'b0000;

        tick();
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_srv_irq", 32'(irq), 32'h0);
        check("t1_srv_id", 32'(id), 32'd2);

        // 2: higher-priority edge arrives during service, no nesting
        req = 16'h0025;
        #1;
        check("t2_no_nest", 32'(irq), 32'h0);
        tick();
        check("t2_no_nest2", 32'(irq), 32'h0);
        mret = 1'b1;
        #1;
        check("t2_ret", 32'(ret), 32'h0000_0004);
        tick();
        mret = 1'b0;
        req  = 16'h0000;
        #1;
        check("t2_ret_once", 32'(ret), 32'h0);
        check("t2_busy_clr", 32'(busy), 32'h0);
        check("t2_irq", 32'(irq), 32'h1);
        check("t2_id", 32'(id), 32'd0);
        check("t2_cause", cause, 32'h8000_0010);
        tick();
        check("t2_busy", 32'(busy), 32'h1);
        mret = 1'b1;
        #1;
        check("t2_ret0", 32'(ret), 32'h0000_0001);
        tick();
        mret = 1'b0;
        #1;
        check("t2_pend_clr", 32'(irq), 32'h0);

        // 3: masked edge pulse is retained until enabled
        mie = 16'hFFFE;
        req = 16'h0001;
        tick();
        req = 16'h0000;
        #1;
        check("t3_masked", 32'(irq), 32'h0);
        repeat (9) tick();
        check("t3_masked_late", 32'(irq), 32'h0);
        check("t3_idle", 32'(busy), 32'h0);
        mie = 16'hFFFF;
        #1;
        check("t3_irq", 32'(irq), 32'h1);
        check("t3_id", 32'(id), 32'd0);
        tick();
        check("t3_busy", 32'(busy), 32'h1);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        #1;
        check("t3_pend_clr", 32'(irq), 32'h0);

        // 4: exception suppresses the trap and keeps IDLE
        exc = 1'b1;
        req = 16'h0020;
        #1;
        check("t4_exc_irq", 32'(irq), 32'h0);
        tick();
        check("t4_exc_idle", 32'(busy), 32'h0);
        exc = 1'b0;
        #1;
        check("t4_irq", 32'(irq), 32'h1);
        check("t4_id", 32'(id), 32'd5);
        check("t4_cause", cause, 32'h8000_0015);
        tick();
        check("t4_busy", 32'(busy), 32'h1);
        exc = 1'b1;
        tick();
        check("t4_exc_srv", 32'(busy), 32'h1);
        exc  = 1'b0;
        req  = 16'h0000;
        mret = 1'b1;
        #1;
        check("t4_ret", 32'(ret), 32'h0000_0020);
        tick();
        mret = 1'b0;

        // 5: mret in IDLE is ignored; global enable gates the trap
        mret = 1'b1;
        #1;
        check("t5_mret_idle_ret", 32'(ret), 32'h0);
        tick();
        check("t5_mret_idle_busy", 32'(busy), 32'h0);
        mret = 1'b0;
        gen  = 1'b0;
        req  = 16'hFFFF;
        #1;
        check("t5_gen_off", 32'(irq), 32'h0);
        tick();
        check("t5_gen_off_idle", 32'(busy), 32'h0);
        gen = 1'b1;
        #1;
        check("t5_gen_on", 32'(irq), 32'h1);
        check("t5_gen_on_id", 32'(id), 32'd0);
        tick();
        check("t5_busy", 32'(busy), 32'h1);

        // 6: asynchronous reset mid-service, edge held across release
        mret  = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_irq", 32'(irq), 32'h0);
        check("t6_rst_ret", 32'(ret), 32'h0);
        check("t6_rst_id", 32'(id), 32'h0);
        mret = 1'b0;
        req  = 16'h0001;
        tick();
        rst_n = 1'b1;
        #1;
        check("t6_release_irq", 32'(irq), 32'h0);
        tick();
        check("t6_edge_irq", 32'(irq), 32'h1);
        check("t6_edge_id", 32'(id), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
